// File: rtl/vrf_wb_scheduler.sv
// Round-robin writeback arbiter for the VRF write port plus busy scoreboard.
// Optional VRF_WB_PRIO_EN: source 0 (load unit) gets fixed top priority.
module vrf_wb_scheduler #(
    parameter int DATA_W = 128,
    parameter int N_SRC  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [5*N_SRC-1:0]      src_waddr,
    input  logic [DATA_W*N_SRC-1:0] src_wdata,
    output logic                    vrf_we,
    output logic [4:0]              vrf_waddr,
    output logic [DATA_W-1:0]       vrf_wdata,
    input  logic                    iss_valid,
    input  logic                    iss_use_vs1,
    input  logic                    iss_use_vs2,
    input  logic                    iss_wr_en,
    input  logic [4:0]              iss_vs1,
    input  logic [4:0]              iss_vs2,
    input  logic [4:0]              iss_vd,
    output logic                    iss_stall,
    output logic [31:0]             busy,
    output logic                    err_wb_unexpected
);

    localparam int PW = $clog2(N_SRC);
    localparam logic [PW-1:0] LAST_RST = PW'(N_SRC - 1);

    logic [PW-1:0]     last_grant_q, last_grant_d;
    logic              vrf_we_q, vrf_we_d;
    logic [4:0]        vrf_waddr_q, vrf_waddr_d;
    logic [DATA_W-1:0] vrf_wdata_q, vrf_wdata_d;
    logic [31:0]       busy_q, busy_d;
    logic              err_q, err_d;

    logic          found;
    logic [PW-1:0] gidx;

    always_comb begin : arb
        int c;
        found = 1'b0;
        gidx  = '0;
`ifdef VRF_WB_PRIO_EN
        if (src_valid[0]) found = 1'b1;
`endif
        for (int k = 1; k <= N_SRC; k++) begin
            c = int'(last_grant_q) + k;
            if (c >= N_SRC) c = c - N_SRC;
            if (!found && src_valid[c]) begin
                found = 1'b1;
                gidx  = PW'(c);
            end
        end
        last_grant_d = last_grant_q;
`ifdef VRF_WB_PRIO_EN
        // Load-unit grants must not disturb the rotation among the others
        if (found && gidx != '0) last_grant_d = gidx;
`else
        if (found) last_grant_d = gidx;
`endif
    end

    always_comb begin
        src_ready = '0;
        if (found) src_ready[gidx] = 1'b1;
    end

    always_comb begin
        vrf_we_d    = found;
        vrf_waddr_d = vrf_waddr_q;
        vrf_wdata_d = vrf_wdata_q;
        if (found) begin
            vrf_waddr_d = src_waddr[int'(gidx)*5 +: 5];
            vrf_wdata_d = src_wdata[int'(gidx)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        iss_stall = iss_valid &&
                    ((iss_use_vs1 && busy_q[iss_vs1]) ||
                     (iss_use_vs2 && busy_q[iss_vs2]) ||
                     (iss_wr_en   && busy_q[iss_vd]));
    end

    // Clear first so that a same-cycle issue to the same register wins
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (vrf_we_q) begin
            if (!busy_q[vrf_waddr_q]) err_d = 1'b1;
            busy_d[vrf_waddr_q] = 1'b0;
        end
        if (iss_valid && iss_wr_en && !iss_stall) busy_d[iss_vd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= LAST_RST;
            vrf_we_q     <= 1'b0;
            vrf_waddr_q  <= '0;
            vrf_wdata_q  <= '0;
            busy_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            vrf_we_q     <= vrf_we_d;
            vrf_waddr_q  <= vrf_waddr_d;
            vrf_wdata_q  <= vrf_wdata_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign vrf_we            = vrf_we_q;
    assign vrf_waddr         = vrf_waddr_q;
    assign vrf_wdata         = vrf_wdata_q;
    assign busy              = busy_q;
    assign err_wb_unexpected = err_q;

endmodule

// File: tb/tb_vrf_wb_scheduler.sv
// Directed plus randomized bench for vrf_wb_scheduler against a
// transaction-level model of arbitration, output stage and scoreboard.
module tb_vrf_wb_scheduler;

    localparam int N  = 3;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [5*N-1:0]  src_waddr = '0;
    logic [DW*N-1:0] src_wdata = '0;
    logic            vrf_we;
    logic [4:0]      vrf_waddr;
    logic [DW-1:0]   vrf_wdata;
    logic            iss_valid = 1'b0;
    logic            iss_use_vs1 = 1'b0;
    logic            iss_use_vs2 = 1'b0;
    logic            iss_wr_en = 1'b0;
    logic [4:0]      iss_vs1 = '0;
    logic [4:0]      iss_vs2 = '0;
    logic [4:0]      iss_vd = '0;
    logic            iss_stall;
    logic [31:0]     busy;
    logic            err_wb_unexpected;

    vrf_wb_scheduler #(.DATA_W(DW), .N_SRC(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_waddr(src_waddr), .src_wdata(src_wdata),
        .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .iss_valid(iss_valid), .iss_use_vs1(iss_use_vs1),
        .iss_use_vs2(iss_use_vs2), .iss_wr_en(iss_wr_en),
        .iss_vs1(iss_vs1), .iss_vs2(iss_vs2), .iss_vd(iss_vd),
        .iss_stall(iss_stall), .busy(busy),
        .err_wb_unexpected(err_wb_unexpected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int            m_last = N - 1;
    logic          m_we = 1'b0;
    logic [4:0]    m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [31:0]   m_busy = '0;
    logic          m_err = 1'b0;
    int            g_last = -1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input int last, input logic [N-1:0] v);
`ifdef VRF_WB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] er;
        logic es;
        #1;
        g  = model_grant(m_last, src_valid);
        er = (g < 0) ? '0 : (N'(1) << g);
        es = iss_valid && ((iss_use_vs1 && m_busy[iss_vs1]) ||
                           (iss_use_vs2 && m_busy[iss_vs2]) ||
                           (iss_wr_en && m_busy[iss_vd]));
        chk("src_ready", 128'(src_ready), 128'(er));
        chk("iss_stall", 128'(iss_stall), 128'(es));
        @(posedge clk);
        if (!rst_n) begin
            m_we = 0; m_waddr = 0; m_wdata = 0;
            m_busy = 0; m_err = 0; m_last = N - 1;
            g = -1;
        end else begin
            if (m_we && !m_busy[m_waddr]) m_err = 1'b1;
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (iss_valid && iss_wr_en && !es) m_busy[iss_vd] = 1'b1;
            m_we = (g >= 0);
            if (g >= 0) begin
                m_waddr = src_waddr[g*5 +: 5];
                m_wdata = src_wdata[g*DW +: DW];
`ifdef VRF_WB_PRIO_EN
                if (g != 0) m_last = g;
`else
                m_last = g;
`endif
            end
        end
        g_last = g;
        #1;
        chk("vrf_we", 128'(vrf_we), 128'(m_we));
        chk("vrf_waddr", 128'(vrf_waddr), 128'(m_waddr));
        chk("vrf_wdata", 128'(vrf_wdata), 128'(m_wdata));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("err", 128'(err_wb_unexpected), 128'(m_err));
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] a,
                           input logic [DW-1:0] d);
        src_valid[i] = v;
        src_waddr[i*5 +: 5] = a;
        src_wdata[i*DW +: DW] = d;
    endtask

    task automatic set_iss(input logic v, input logic u1, input logic u2,
                           input logic w, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d);
        iss_valid = v; iss_use_vs1 = u1; iss_use_vs2 = u2; iss_wr_en = w;
        iss_vs1 = s1; iss_vs2 = s2; iss_vd = d;
    endtask

    task automatic do_reset();
        src_valid = '0;
        set_iss(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_we", 128'(vrf_we), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err_wb_unexpected), 128'(0));
        chk("rst_stall", 128'(iss_stall), 128'(0));

        // Issue vd=4, then source 1 writes it back
        set_iss(1, 0, 0, 1, 0, 0, 5'd4);
        step();
        chk("busy_vd4", 128'(busy), 128'h10);
        set_iss(0, 0, 0, 0, 0, 0, 0);
        set_src(1, 1, 5'd4, {16{8'hA5}});
        step();
        set_src(1, 0, 0, 0);
        chk("wb4_we", 128'(vrf_we), 128'(1));
        chk("wb4_addr", 128'(vrf_waddr), 128'(4));
        chk("wb4_data", 128'(vrf_wdata), {16{8'hA5}});
        step();
        chk("wb4_busy", 128'(busy), 128'(0));
        chk("wb4_err", 128'(err_wb_unexpected), 128'(0));

        // All three sources continuously valid: grants rotate 0,1,2
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 1, 5'(i + 1), DW'(i + 16));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 128'(src_ready), 128'(1 << (k % 3)));
            step();
            chk("rr_we", 128'(vrf_we), 128'(1));
            chk("rr_addr", 128'(vrf_waddr), 128'((k % 3) + 1));
        end
        src_valid = '0;

        // RAW on vr7 stalls through the writeback cycle
        do_reset();
        set_iss(1, 0, 0, 1, 0, 0, 5'd7);
        step();
        set_iss(1, 1, 0, 0, 5'd7, 0, 0);
        #1 chk("raw_stall0", 128'(iss_stall), 128'(1));
        set_src(2, 1, 5'd7, DW'(77));
        step();
        set_src(2, 0, 0, 0);
        chk("raw_stall_we", 128'(iss_stall), 128'(1));
        chk("raw_we", 128'(vrf_we), 128'(1));
        step();
        chk("raw_stall_clr", 128'(iss_stall), 128'(0));

        // Same-cycle set/clear of vr9, then WAW stall
        set_iss(0, 0, 0, 0, 0, 0, 0);
        set_src(0, 1, 5'd9, DW'(9));
        step();
        set_src(0, 0, 0, 0);
        set_iss(1, 0, 0, 1, 0, 0, 5'd9);
        chk("sc_stall", 128'(iss_stall), 128'(0));
        step();
        chk("sc_busy9", 128'(busy[9]), 128'(1));
        chk("waw_stall", 128'(iss_stall), 128'(1));
        iss_valid = 1'b0;
        #1 chk("inval_stall", 128'(iss_stall), 128'(0));

        // Unexpected writeback to vr12 is sticky until reset
        do_reset();
        set_src(1, 1, 5'd12, DW'(12));
        step();
        set_src(1, 0, 0, 0);
        step();
        chk("err12", 128'(err_wb_unexpected), 128'(1));
        step();
        step();
        chk("err12_sticky", 128'(err_wb_unexpected), 128'(1));
        do_reset();
        chk("err12_rst", 128'(err_wb_unexpected), 128'(0));

`ifdef VRF_WB_PRIO_EN
        set_src(0, 1, 5'd1, DW'(1));
        set_src(2, 1, 5'd2, DW'(2));
        for (int k = 0; k < 3; k++) begin
            #1 chk("prio_ready0", 128'(src_ready), 128'(1));
            step();
        end
        set_src(0, 0, 0, 0);
        #1 chk("prio_ready2", 128'(src_ready), 128'(4));
        step();
        src_valid = '0;
`endif

        // Reset mid-burst drops pending write and busy
        do_reset();
        set_iss(1, 0, 0, 1, 0, 0, 5'd5);
        for (int i = 0; i < N; i++) set_src(i, 1, 5'(i + 1), DW'(i));
        step();
        set_iss(0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_we", 128'(vrf_we), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        src_valid = '0;
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (g_last == i || !src_valid[i])
                    set_src(i, 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 7)),
                            {$urandom, $urandom, $urandom, $urandom});
            end
            set_iss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
            if (n == 300) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vrf_wb_scheduler.md
Name: vrf_wb_scheduler

Overview:
Shares the single write port of the 32-entry vector register file among N_SRC writeback sources (e.g. VALU, load unit, reduction unit) using round-robin arbitration and a registered output stage. It also keeps a 32-bit busy scoreboard: issue marks a destination register pending, writeback clears it, and RAW/WAW hazards stall issue. The block sits between the execution units, the issue stage and the vector register file write port.

Parameters:
DATA_W, 128, vector register width in bits (matches the register file)
N_SRC, 3, number of writeback sources (2..8)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
src_valid  in  N_SRC  per-source writeback request
src_ready  out  N_SRC  per-source grant; transfer occurs when valid && ready
src_waddr  in  5*N_SRC  per-source destination register; source i uses bits [5i+4:5i]
src_wdata  in  DATA_W*N_SRC  per-source write data; source i uses slice i
vrf_we  out  1  register file write enable
vrf_waddr  out  5  register file write address
vrf_wdata  out  DATA_W  register file write data
iss_valid  in  1  issue stage presenting an instruction
iss_use_vs1  in  1  instruction reads vs1
iss_use_vs2  in  1  instruction reads vs2
iss_wr_en  in  1  instruction writes vd
iss_vs1  in  5  source register 1
iss_vs2  in  5  source register 2
iss_vd  in  5  destination register
iss_stall  out  1  hazard; issue must hold
busy  out  32  scoreboard, bit r = write to vr r pending
err_wb_unexpected  out  1  sticky; writeback targeted a non-busy register

Behaviour:
- Reset (rst_n low at posedge): vrf_we=0, vrf_waddr=0, vrf_wdata=0, busy=0, err_wb_unexpected=0, RR pointer last_grant=N_SRC-1 so source 0 has highest priority first. src_ready and iss_stall are combinational; with busy=0, iss_stall=0.
- Arbitration (combinational): search src_valid starting at (last_grant+1) mod N_SRC, wrapping. The first valid source g gets src_ready[g]=1; all other ready bits are 0. No valid source means no ready bits.
  - At most one grant per cycle.
  - Ready never depends on downstream state, because the register file always accepts.
  - Sources must hold valid/waddr/wdata stable until ready.
- Grant update: on a transfer, last_grant<=g. If no transfer, last_grant holds.
- Output stage: latency is exactly 1 cycle. After a transfer in cycle N, in cycle N+1 vrf_we=1 with that source's waddr/wdata; the register file writes at the end of N+1. Without a transfer, vrf_we=0 and vrf_waddr/vrf_wdata hold their previous values.
- Back-to-back grants sustain 1 write/cycle.
- Scoreboard:
  - Set: iss_valid && iss_wr_en && !iss_stall sets busy[iss_vd] at the edge.
  - Clear: vrf_we clears busy[vrf_waddr] at the same edge the register file writes.
  - Set and clear of the same register in one cycle: set wins (busy stays 1).
- Unexpected writeback: vrf_we to a register with busy=0 sets err_wb_unexpected. The flag clears only on reset.
- Hazard (combinational, uses current busy):
  - iss_stall = iss_valid && ((iss_use_vs1 && busy[iss_vs1]) || (iss_use_vs2 && busy[iss_vs2]) || (iss_wr_en && busy[iss_vd])).
  - While vrf_we targets vs1, busy is still 1, so issue stalls. The next cycle busy=0 and the combinational read returns new data; no bypass is required.
- iss_valid=0 forces iss_stall=0.
- Reset mid-operation discards pending output-stage writes (vrf_we=0 next cycle) and clears busy. Sources re-present after reset.

Optional Feature:
VRF_WB_PRIO_EN: when defined, source 0 (load unit) has fixed highest priority: if src_valid[0], grant 0. Round-robin among sources 1..N_SRC-1 applies only when src_valid[0]=0, and last_grant updates only on grants to sources 1..N_SRC-1. When undefined, all sources are pure round-robin as described above.

Test Plan:
- Reset then issue vd=4 (wr_en=1): busy=0x00000010 next cycle. Src1 writes vr4 data 0xA5..A5: vrf_we=1, waddr=4 one cycle later; busy=0 after that edge; err=0.
- All 3 sources valid continuously (waddr 1,2,3), PRIO_EN off: grants 0,1,2,0,1,2 on consecutive cycles; vrf_we high every cycle from cycle 1.
- RAW: busy[7]=1, issue vs1=7 use_vs1=1: iss_stall=1 held, including during the vrf_we cycle for vr7; stall=0 the cycle after.
- Same-cycle set/clear: vrf_we to vr9 while issuing vd=9 unstalled (busy[9]=0 via other path): busy[9]=1 afterward. Separately, WAW on busy vd=9 -> iss_stall=1.
- Writeback to vr12 with busy[12]=0: err_wb_unexpected=1 and sticky until rst_n=0.
- PRIO_EN on, sources 0 and 2 valid for 3 cycles, then source 0 drops: grants 0,0,0,2. Reset asserted mid-burst: next cycle vrf_we=0, busy=0.
